reversible_mod_counter: RTL and testbench



---
 rtl/reversible_mod_counter.sv | 93 +++++++++
 tb/tb_reversible_mod_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reversible_mod_counter.sv
//------------------------------------------------------------------------------
// Module      : reversible_mod_counter
// Description : Up/down modulo-(MAX+1) counter with parallel load, optional
//               saturation, cascade terminal count and wrap/load-error pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reversible_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 2**WIDTH-1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CP,
    input  logic             RESET,
    input  logic             L,
    input  logic             C,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             LDERR
);

    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             r_wrap_q;
    logic             w_wrap_d;
    logic             r_lderr_q;
    logic             w_lderr_d;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (r_count_q == c_MAX);
    assign w_at_zero = (r_count_q == c_ZERO);

    // Pulses default low so they last exactly one cycle unless re-caused.
    always_comb begin
        w_count_d = r_count_q;
        w_wrap_d  = 1'b0;
        w_lderr_d = 1'b0;
        if (L) begin
            if (D > c_MAX) begin
                w_count_d = c_MAX;
                w_lderr_d = 1'b1;
            end else begin
                w_count_d = D;
            end
        end else if (C) begin
            if (UP) begin
                if (!w_at_max) begin
                    w_count_d = r_count_q + c_ONE;
                end else if (!SATURATE) begin
                    w_count_d = c_ZERO;
                    w_wrap_d  = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_count_d = r_count_q - c_ONE;
                end else if (!SATURATE) begin
                    w_count_d = c_MAX;
                    w_wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CP) begin
        if (RESET) begin
            r_count_q <= c_ZERO;
            r_wrap_q  <= 1'b0;
            r_lderr_q <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_wrap_q  <= w_wrap_d;
            r_lderr_q <= w_lderr_d;
        end
    end

    // Terminal count ignores SATURATE so a saturating stage still carries.
    assign TC    = C & ~L & ((UP & w_at_max) | (~UP & w_at_zero));
    assign Q     = r_count_q;
    assign WRAP  = r_wrap_q;
    assign LDERR = r_lderr_q;

endmodule

`default_nettype wire

// File: tb/tb_reversible_mod_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_reversible_mod_counter
// Description : Directed self-checking bench for reversible_mod_counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reversible_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // a_*: MAX=9 wrap, s_*: MAX=9 saturate, f_*: full-range, k_*/t_*: cascade
    logic       a_rst, a_l, a_c, a_up;
    logic [3:0] a_d, a_q;
    logic       a_tc, a_wrap, a_lderr;
    logic       s_rst, s_l, s_c, s_up;
    logic [3:0] s_d, s_q;
    logic       s_tc, s_wrap, s_lderr;
    logic       f_rst, f_l, f_c, f_up;
    logic [3:0] f_d, f_q;
    logic       f_tc, f_wrap, f_lderr;
    logic       k_rst, k_c, k_up;
    logic [3:0] k_q, t_q;
    logic       k_tc, k_wrap, k_lderr, t_tc, t_wrap, t_lderr;
    logic       k_l = 1'b0;
    logic [3:0] k_d = 4'd0;

    reversible_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_a (
        .CP(clk), .RESET(a_rst), .L(a_l), .C(a_c), .UP(a_up), .D(a_d),
        .Q(a_q), .TC(a_tc), .WRAP(a_wrap), .LDERR(a_lderr));
    reversible_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_s (
        .CP(clk), .RESET(s_rst), .L(s_l), .C(s_c), .UP(s_up), .D(s_d),
        .Q(s_q), .TC(s_tc), .WRAP(s_wrap), .LDERR(s_lderr));
    reversible_mod_counter #(.WIDTH(4)) u_f (
        .CP(clk), .RESET(f_rst), .L(f_l), .C(f_c), .UP(f_up), .D(f_d),
        .Q(f_q), .TC(f_tc), .WRAP(f_wrap), .LDERR(f_lderr));
    reversible_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_ones (
        .CP(clk), .RESET(k_rst), .L(k_l), .C(k_c), .UP(k_up), .D(k_d),
        .Q(k_q), .TC(k_tc), .WRAP(k_wrap), .LDERR(k_lderr));
    reversible_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_tens (
        .CP(clk), .RESET(k_rst), .L(k_l), .C(k_tc), .UP(k_up), .D(k_d),
        .Q(t_q), .TC(t_tc), .WRAP(t_wrap), .LDERR(t_lderr));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1; a_l = 1; a_c = 1; a_up = 1; a_d = 4'd13;
        s_rst = 1; s_l = 0; s_c = 0; s_up = 1; s_d = 0;
        f_rst = 1; f_l = 0; f_c = 0; f_up = 1; f_d = 0;
        k_rst = 1; k_c = 0; k_up = 1;
        step();
        step();
        total++;
        if (a_q !== 4'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", a_q); end
        total++;
        if (a_wrap !== 1'b0 || a_lderr !== 1'b0) begin
            bad++; $display("FAIL reset_pulses got wrap=%b lderr=%b exp=0,0", a_wrap, a_lderr);
        end
        a_l = 0; a_c = 1; a_up = 0; #1;
        total++;
        if (a_tc !== 1'b1) begin bad++; $display("FAIL reset_tc_down got=%b exp=1", a_tc); end
        a_up = 1; #1;
        total++;
        if (a_tc !== 1'b0) begin bad++; $display("FAIL reset_tc_up got=%b exp=0", a_tc); end
        a_c = 0;
        a_rst = 0; s_rst = 0; f_rst = 0; k_rst = 0;
    endtask

    task automatic test_count_up();
        int exp_q;
        a_l = 0; a_c = 1; a_up = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_q = (i + 1) % 10;
            total++;
            if (a_q !== 4'(exp_q)) begin bad++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, a_q, exp_q); end
            total++;
            if (a_wrap !== (i == 9)) begin bad++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, a_wrap, i == 9); end
            total++;
            if (a_tc !== (exp_q == 9)) begin bad++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, a_tc, exp_q == 9); end
        end
        a_c = 0;
    endtask

    task automatic test_count_down();
        int exp_seq [4] = '{1, 0, 9, 8};
        a_l = 1; a_d = 4'd2; a_c = 0;
        step();
        total++;
        if (a_q !== 4'd2) begin bad++; $display("FAIL down_load got=%0d exp=2", a_q); end
        a_l = 0; a_c = 1; a_up = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (a_q !== 4'(exp_seq[i])) begin bad++; $display("FAIL down_q[%0d] got=%0d exp=%0d", i, a_q, exp_seq[i]); end
            total++;
            if (a_wrap !== (i == 2)) begin bad++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, a_wrap, i == 2); end
            total++;
            if (a_tc !== (exp_seq[i] == 0)) begin bad++; $display("FAIL down_tc[%0d] got=%b exp=%b", i, a_tc, exp_seq[i] == 0); end
        end
        a_c = 0;
    endtask

    task automatic test_load_clamp();
        a_d = 4'd13; a_l = 1; a_c = 1; a_up = 1;
        step();
        total++;
        if (a_q !== 4'd9 || a_lderr !== 1'b1 || a_wrap !== 1'b0) begin
            bad++; $display("FAIL clamp got q=%0d lderr=%b wrap=%b exp 9,1,0", a_q, a_lderr, a_wrap);
        end
        total++;
        if (a_tc !== 1'b0) begin bad++; $display("FAIL clamp_tc_load got=%b exp=0", a_tc); end
        a_d = 4'd14;
        step();
        total++;
        if (a_q !== 4'd9 || a_lderr !== 1'b1) begin
            bad++; $display("FAIL clamp_b2b got q=%0d lderr=%b exp 9,1", a_q, a_lderr);
        end
        a_d = 4'd5; a_c = 0;
        step();
        total++;
        if (a_q !== 4'd5 || a_lderr !== 1'b0) begin
            bad++; $display("FAIL load_ok got q=%0d lderr=%b exp 5,0", a_q, a_lderr);
        end
        a_d = 4'd9;
        step();
        total++;
        if (a_q !== 4'd9 || a_lderr !== 1'b0) begin
            bad++; $display("FAIL load_max got q=%0d lderr=%b exp 9,0", a_q, a_lderr);
        end
        a_l = 0; a_c = 0; a_d = 4'd3;
        step();
        total++;
        if (a_q !== 4'd9 || a_lderr !== 1'b0 || a_wrap !== 1'b0) begin
            bad++; $display("FAIL hold got q=%0d lderr=%b wrap=%b exp 9,0,0", a_q, a_lderr, a_wrap);
        end
    endtask

    task automatic test_saturate();
        s_l = 1; s_d = 4'd8; s_c = 0;
        step();
        s_l = 0; s_c = 1; s_up = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (s_q !== 4'd9 || s_wrap !== 1'b0 || s_tc !== 1'b1) begin
                bad++; $display("FAIL sat_up[%0d] got q=%0d wrap=%b tc=%b exp 9,0,1", i, s_q, s_wrap, s_tc);
            end
        end
        s_l = 1; s_d = 4'd1; s_c = 0;
        step();
        s_l = 0; s_c = 1; s_up = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (s_q !== 4'd0 || s_wrap !== 1'b0 || s_tc !== 1'b1) begin
                bad++; $display("FAIL sat_down[%0d] got q=%0d wrap=%b tc=%b exp 0,0,1", i, s_q, s_wrap, s_tc);
            end
        end
        s_c = 0;
    endtask

    task automatic test_reset_mid();
        a_l = 1; a_d = 4'd9; a_c = 0;
        step();
        a_l = 0; a_c = 1; a_up = 1; a_rst = 1;
        step();
        total++;
        if (a_q !== 4'd0 || a_wrap !== 1'b0) begin
            bad++; $display("FAIL rst_mid_count got q=%0d wrap=%b exp 0,0", a_q, a_wrap);
        end
        a_rst = 0;
        step();
        total++;
        if (a_q !== 4'd1) begin bad++; $display("FAIL rst_mid_next got=%0d exp=1", a_q); end
        a_l = 1; a_d = 4'd13; a_rst = 1;
        step();
        total++;
        if (a_q !== 4'd0 || a_lderr !== 1'b0) begin
            bad++; $display("FAIL rst_mid_load got q=%0d lderr=%b exp 0,0", a_q, a_lderr);
        end
        a_rst = 0; a_l = 0; a_c = 0;
    endtask

    task automatic test_full_range();
        f_l = 1; f_d = 4'd15;
        step();
        total++;
        if (f_q !== 4'd15 || f_lderr !== 1'b0) begin
            bad++; $display("FAIL full_load got q=%0d lderr=%b exp 15,0", f_q, f_lderr);
        end
        f_l = 0; f_c = 1; f_up = 1;
        step();
        total++;
        if (f_q !== 4'd0 || f_wrap !== 1'b1) begin
            bad++; $display("FAIL full_wrap_up got q=%0d wrap=%b exp 0,1", f_q, f_wrap);
        end
        f_up = 0;
        step();
        total++;
        if (f_q !== 4'd15 || f_wrap !== 1'b1) begin
            bad++; $display("FAIL full_wrap_down got q=%0d wrap=%b exp 15,1", f_q, f_wrap);
        end
        f_c = 0;
    endtask

    task automatic test_cascade();
        int ones = 0;
        int tens = 0;
        int twraps = 0;
        bit carry;
        bit exp_twrap;
        bit seen99 = 0;
        k_rst = 1;
        step();
        k_rst = 0; k_c = 1; k_up = 1;
        for (int i = 0; i < 100; i++) begin
            carry = (ones == 9);
            step();
            ones = (ones + 1) % 10;
            exp_twrap = 0;
            if (carry) begin
                exp_twrap = (tens == 9);
                tens = (tens + 1) % 10;
            end
            if (ones == 9 && tens == 9) seen99 = 1;
            if (t_wrap) twraps++;
            total++;
            if (k_q !== 4'(ones) || t_q !== 4'(tens) || t_wrap !== exp_twrap) begin
                bad++;
                $display("FAIL cascade[%0d] got %0d%0d twrap=%b exp %0d%0d twrap=%b",
                         i, t_q, k_q, t_wrap, tens, ones, exp_twrap);
            end
        end
        total++;
        if (twraps != 1 || !seen99 || t_q !== 4'd0 || k_q !== 4'd0) begin
            bad++; $display("FAIL cascade_end got twraps=%0d final=%0d%0d exp 1 wrap, final 00", twraps, t_q, k_q);
        end
        k_c = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_saturate();
        test_reset_mid();
        test_full_range();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
